hs_ram_uploader: RTL and testbench
==================================

// Module: hs_ram_uploader
// PURPOSE
//  Read side of the hiscore/NVRAM path: serves HPS upload requests (ioctl_upload/ioctl_rd) by reading game RAM bytes
//  into ioctl_din, stalling HPS with ioctl_wait. Pauses the CPU for the whole upload so the snapshot is consistent.
//  Tracks game writes to the saved region and pulses ioctl_upload_req on OSD open when autosave is on and data is dirty.
//  Sits beside hps_io in clk_sys domain; its pause_req ORs into the pause block's pause_request.
// PARAMETERS
//  ADDR_W     16      game RAM address width
//  BASE_ADDR  16'h0   first game RAM address of the saved region
//  LENGTH     64      bytes in saved region (1..2**ADDR_W)
//  RAM_LAT    1       cycles from ram_rd to ram_q valid (1..4)
//  SETTLE     16      cycles after paused rises before first RAM read
// PORTS
//  clk_sys          in   1       system clock
//  reset            in   1       synchronous, active-high
//  upload_en        in   1       ioctl_index selects this block
//  ioctl_upload     in   1       HPS upload active
//  ioctl_rd         in   1       1-cycle byte request at ioctl_addr
//  ioctl_addr       in   25      byte offset within region
//  ioctl_din        out  8       byte to HPS
//  ioctl_wait       out  1       HPS stall
//  ioctl_upload_req out  1       1-cycle autosave request
//  autosave         in   1       autosave option
//  osd_status       in   1       OSD open level
//  pause_req        out  1       request CPU pause
//  paused           in   1       CPU confirmed paused
//  ram_addr         out  ADDR_W  RAM read address
//  ram_rd           out  1       RAM read strobe
//  ram_q            in   8       RAM read data
//  game_we          in   1       game CPU RAM write strobe
//  game_addr        in   ADDR_W  game CPU write address
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, dirty=0, settle counter 0, osd_status history 0.
//  act = upload_en & ioctl_upload. FSM states IDLE, PAUSE, READY, FETCH:
//   IDLE : pause_req=0. act rising -> PAUSE, pause_req=1 next cycle.
//   PAUSE: count SETTLE cycles while paused=1 (counter clears if paused drops). Done -> READY.
//          ioctl_rd here: ioctl_wait=1 next cycle, request held pending until READY.
//   READY: ioctl_rd (or pending) with ioctl_addr<LENGTH -> FETCH; ram_addr=BASE_ADDR+ioctl_addr[ADDR_W-1:0]
//          (modulo 2**ADDR_W), ram_rd=1 for exactly one cycle, ioctl_wait=1.
//          ioctl_addr>=LENGTH -> ioctl_din=8'h00 next cycle, no RAM access, ioctl_wait stays 0.
//   FETCH: count RAM_LAT cycles; then ioctl_din<=ram_q and ioctl_wait<=0 in same edge -> READY.
//  Latency with paused already settled: ioctl_rd at cycle 0; ram_rd cycle 1; ioctl_wait high cycles 1..RAM_LAT+1;
//   ioctl_din valid and wait low at cycle RAM_LAT+2.
//  ioctl_rd while FETCH: ignored (HPS must honour wait); never queued.
//  act falls in any state: -> IDLE next cycle; pause_req, ioctl_wait, ram_rd cleared; pending dropped; ioctl_din held.
//  Completed upload (act falls after addr LENGTH-1 served) clears dirty.
//  Dirty: set on game_we with BASE_ADDR<=game_addr<BASE_ADDR+LENGTH (compare in ADDR_W+1 bits, no wrap).
//   Simultaneous set and clear: set wins.
//  ioctl_upload_req: 1-cycle pulse on osd_status rising edge iff autosave & dirty & state==IDLE; else none.
//  Reset mid-upload: immediate return to reset values; HPS sees wait=0.
// STRUCTURE
//  Package hs_upload_pkg: typedef enum logic [1:0] {ST_IDLE,ST_PAUSE,ST_READY,ST_FETCH}; localparam widths of
//   settle/latency counters ($clog2(SETTLE+1), $clog2(RAM_LAT+1)).
//  Sub-module hs_dirty_tracker: range compare on game writes, set/clear flag, OSD edge detect, upload_req pulse.
//  Top: FSM, counters, address add, ioctl_din/ioctl_wait registers.
// TESTING
//  LENGTH=64,BASE=16'hC000,RAM_LAT=1,SETTLE=16: upload rising, paused=1 at +2 -> pause_req=1 at +1, first ram_rd no
//   earlier than 16 cycles after paused; rd addr 5 -> ram_addr=16'hC005, ioctl_din=model[C005], wait high 2 cycles.
//  rd addr 64 and addr 200 -> ioctl_din=8'h00, wait never asserted, ram_rd never pulses.
//  paused drops mid-PAUSE at count 10 -> counter restarts; pending rd served only after 16 full paused cycles.
//  game_we at 16'hC03F sets dirty, 16'hC040 and 16'hBFFF do not; osd_status 0->1 with autosave=1 -> one-cycle
//   ioctl_upload_req; autosave=0 or dirty=0 -> none; full upload 0..63 then act fall -> dirty=0.
//  ioctl_upload drops during FETCH -> next cycle IDLE, wait=0, pause_req=0; re-upload works normally.
//  reset asserted during FETCH -> next cycle all outputs 0, dirty=0; random rd stream vs RAM model, RAM_LAT=1..4.

Source files
------------

// File: rtl/hs_upload_pkg.sv
// Shared types and helpers for the hiscore/NVRAM upload path.
//   state_t      : upload FSM states
//   IOCTL_ADDR_W : width of the HPS ioctl byte address
//   cnt_w()      : width of a counter that has to hold the value max_count
package hs_upload_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAUSE,
    ST_READY,
    ST_FETCH
  } state_t;

  localparam int IOCTL_ADDR_W = 25;

  function automatic int cnt_w(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/hs_ram_uploader_if.sv
// HPS ioctl upload bus as seen by the hiscore uploader.
//   master : hps_io side (drives select/upload/read strobe/address)
//   slave  : uploader side (returns data, wait stall and the autosave request)
interface hs_ram_uploader_if;
  import hs_upload_pkg::*;

  logic                    upload_en;
  logic                    ioctl_upload;
  logic                    ioctl_rd;
  logic [IOCTL_ADDR_W-1:0] ioctl_addr;
  logic [7:0]              ioctl_din;
  logic                    ioctl_wait;
  logic                    ioctl_upload_req;

  modport master (
    output upload_en, ioctl_upload, ioctl_rd, ioctl_addr,
    input  ioctl_din, ioctl_wait, ioctl_upload_req
  );

  modport slave (
    input  upload_en, ioctl_upload, ioctl_rd, ioctl_addr,
    output ioctl_din, ioctl_wait, ioctl_upload_req
  );
endinterface

// File: rtl/hs_dirty_tracker.sv
// Remembers whether the game has written into the saved RAM region since the
// last complete upload, and asks HPS for an autosave when the OSD opens.
// Ports:
//   clk_sys, reset         : system clock, synchronous active-high reset
//   game_we, game_addr     : game CPU RAM write strobe and address
//   clear                  : a complete upload just finished
//   autosave, osd_status   : autosave option, OSD open level
//   idle                   : uploader FSM is idle
//   upload_req             : one-cycle autosave request to HPS
module hs_dirty_tracker #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LENGTH    = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr,
  input  logic              clear,
  input  logic              autosave,
  input  logic              osd_status,
  input  logic              idle,
  output logic              upload_req
);

  localparam logic [ADDR_W:0] REGION_LEN = (ADDR_W+1)'(LENGTH);

  logic            dirty;
  logic            osd_prev;
  logic [ADDR_W:0] offset;
  logic            in_region;

  // One extra bit keeps the region end from wrapping. An address below the
  // base underflows to at least 2**ADDR_W, which is never below LENGTH, so a
  // single compare covers both region bounds.
  assign offset    = {1'b0, game_addr} - {1'b0, BASE_ADDR};
  assign in_region = (offset < REGION_LEN);

  // A game write in the same cycle as the upload completes keeps the flag set,
  // because that byte may have missed the snapshot.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dirty      <= 1'b0;
      osd_prev   <= 1'b0;
      upload_req <= 1'b0;
    end else begin
      osd_prev   <= osd_status;
      upload_req <= osd_status & ~osd_prev & autosave & dirty & idle;
      if (game_we && in_region) begin
        dirty <= 1'b1;
      end else if (clear) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hs_ram_uploader.sv
// Read side of the hiscore/NVRAM path. Serves HPS upload byte requests by
// reading game RAM, stalling HPS with ioctl_wait, and keeps the CPU paused for
// the whole upload so the snapshot is consistent.
// Ports:
//   clk_sys, reset      : system clock, synchronous active-high reset
//   io (slave)          : HPS ioctl upload bus
//   autosave, osd_status: autosave option, OSD open level
//   pause_req / paused  : CPU pause request and confirmation
//   ram_addr/ram_rd/ram_q: game RAM read port (data RAM_LAT cycles after ram_rd)
//   game_we, game_addr  : game CPU writes, watched for dirtiness
module hs_ram_uploader #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                LENGTH    = 64,
  parameter int                RAM_LAT   = 1,
  parameter int                SETTLE    = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  hs_ram_uploader_if.slave  io,
  input  logic              autosave,
  input  logic              osd_status,
  output logic              pause_req,
  input  logic              paused,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_q,
  input  logic              game_we,
  input  logic [ADDR_W-1:0] game_addr
);
  import hs_upload_pkg::*;

  localparam int SET_W = cnt_w(SETTLE);
  localparam int LAT_W = cnt_w(RAM_LAT);

  state_t                  state, state_nxt;
  logic                    act;
  logic [SET_W-1:0]        settle_cnt;
  logic [LAT_W-1:0]        lat_cnt;
  logic                    pending;
  logic [IOCTL_ADDR_W-1:0] pend_addr;
  logic [IOCTL_ADDR_W-1:0] req_addr;
  logic                    req_valid;
  logic                    req_in_range;
  logic                    settle_done;
  logic                    fetch_done;
  logic                    fetch_last;
  logic                    served_last;
  logic                    capture_pending;
  logic                    start_fetch;
  logic                    null_read;
  logic                    finish_fetch;
  logic                    clear_dirty;

  assign act          = io.upload_en & io.ioctl_upload;
  // A request held from PAUSE takes precedence; HPS is stalled meanwhile.
  assign req_valid    = io.ioctl_rd | pending;
  assign req_addr     = pending ? pend_addr : io.ioctl_addr;
  assign req_in_range = (32'(req_addr) < 32'(LENGTH));
  // SETTLE counts paused cycles; the last one is the cycle that moves to READY.
  assign settle_done  = paused && (settle_cnt == SET_W'(SETTLE - 1));
  assign fetch_done   = (lat_cnt == LAT_W'(RAM_LAT));

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!act) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_PAUSE;
        ST_PAUSE: if (settle_done) state_nxt = ST_READY;
        ST_READY: if (req_valid && req_in_range) state_nxt = ST_FETCH;
        ST_FETCH: if (fetch_done) state_nxt = ST_READY;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pause_req       = (state != ST_IDLE);
    capture_pending = 1'b0;
    start_fetch     = 1'b0;
    null_read       = 1'b0;
    finish_fetch    = 1'b0;
    clear_dirty     = 1'b0;
    if (act) begin
      case (state)
        ST_PAUSE: capture_pending = io.ioctl_rd;
        ST_READY: begin
          start_fetch = req_valid & req_in_range;
          null_read   = req_valid & ~req_in_range;
        end
        ST_FETCH: finish_fetch = fetch_done;
        default:  ;
      endcase
    end else begin
      clear_dirty = served_last;
    end
  end

  // Dropping the upload abandons any request in flight but leaves ioctl_din
  // alone, so HPS never sees a half-updated byte.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      settle_cnt    <= '0;
      lat_cnt       <= '0;
      pending       <= 1'b0;
      pend_addr     <= '0;
      fetch_last    <= 1'b0;
      served_last   <= 1'b0;
      ram_addr      <= '0;
      ram_rd        <= 1'b0;
      io.ioctl_din  <= 8'h00;
      io.ioctl_wait <= 1'b0;
    end else begin
      ram_rd <= start_fetch;

      if (act && state == ST_PAUSE && paused && !settle_done) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      if (act && state == ST_FETCH && !fetch_done) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end else begin
        lat_cnt <= '0;
      end

      if (!act) begin
        pending       <= 1'b0;
        served_last   <= 1'b0;
        io.ioctl_wait <= 1'b0;
      end else begin
        if (capture_pending) begin
          pending       <= 1'b1;
          pend_addr     <= io.ioctl_addr;
          io.ioctl_wait <= 1'b1;
        end
        if (start_fetch) begin
          pending       <= 1'b0;
          ram_addr      <= BASE_ADDR + req_addr[ADDR_W-1:0];
          fetch_last    <= (32'(req_addr) == 32'(LENGTH - 1));
          io.ioctl_wait <= 1'b1;
        end
        if (null_read) begin
          pending       <= 1'b0;
          io.ioctl_din  <= 8'h00;
          io.ioctl_wait <= 1'b0;
        end
        if (finish_fetch) begin
          io.ioctl_din  <= ram_q;
          io.ioctl_wait <= 1'b0;
          if (fetch_last) served_last <= 1'b1;
        end
      end
    end
  end

  hs_dirty_tracker #(
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR),
    .LENGTH    (LENGTH)
  ) u_dirty (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .game_we    (game_we),
    .game_addr  (game_addr),
    .clear      (clear_dirty),
    .autosave   (autosave),
    .osd_status (osd_status),
    .idle       (state == ST_IDLE),
    .upload_req (io.ioctl_upload_req)
  );

endmodule

// File: tb/tb_hs_ram_uploader.sv
// Directed bench for hs_ram_uploader. Two instances share all stimulus and
// differ only in RAM latency (1 and 4); each has its own RAM model that only
// presents valid data exactly RAM_LAT cycles after ram_rd.
module tb_hs_ram_uploader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        upload_en = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic        autosave = 1'b0;
  logic        osd_status = 1'b0;
  logic        paused = 1'b0;
  logic        game_we = 1'b0;
  logic [15:0] game_addr = '0;

  logic        pause_req1, pause_req4;
  logic [15:0] ram_addr1, ram_addr4;
  logic        ram_rd1, ram_rd4;
  logic [7:0]  ram_q1, ram_q4;

  int n_checks = 0;
  int n_fail   = 0;

  hs_ram_uploader_if io1();
  hs_ram_uploader_if io4();

  assign io1.upload_en    = upload_en;
  assign io1.ioctl_upload = ioctl_upload;
  assign io1.ioctl_rd     = ioctl_rd;
  assign io1.ioctl_addr   = ioctl_addr;
  assign io4.upload_en    = upload_en;
  assign io4.ioctl_upload = ioctl_upload;
  assign io4.ioctl_rd     = ioctl_rd;
  assign io4.ioctl_addr   = ioctl_addr;

  always #5 clk_sys = ~clk_sys;

  hs_ram_uploader #(
    .ADDR_W(16), .BASE_ADDR(16'hC000), .LENGTH(64), .RAM_LAT(1), .SETTLE(16)
  ) dut1 (
    .clk_sys(clk_sys), .reset(reset), .io(io1), .autosave(autosave),
    .osd_status(osd_status), .pause_req(pause_req1), .paused(paused),
    .ram_addr(ram_addr1), .ram_rd(ram_rd1), .ram_q(ram_q1),
    .game_we(game_we), .game_addr(game_addr)
  );

  hs_ram_uploader #(
    .ADDR_W(16), .BASE_ADDR(16'hC000), .LENGTH(64), .RAM_LAT(4), .SETTLE(16)
  ) dut4 (
    .clk_sys(clk_sys), .reset(reset), .io(io4), .autosave(autosave),
    .osd_status(osd_status), .pause_req(pause_req4), .paused(paused),
    .ram_addr(ram_addr4), .ram_rd(ram_rd4), .ram_q(ram_q4),
    .game_we(game_we), .game_addr(game_addr)
  );

  function automatic logic [7:0] ram_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ {a[11:8], a[15:12]};
  endfunction

  // RAM models: data is only valid on the exact cycle it is due, else 8'hEE.
  logic        rv1 = 1'b0;
  logic [15:0] ra1 = '0;
  logic [3:0]  rv4 = '0;
  logic [15:0] ra4 [4];

  always @(posedge clk_sys) begin
    rv1    <= ram_rd1;
    ra1    <= ram_addr1;
    rv4    <= {rv4[2:0], ram_rd4};
    ra4[0] <= ram_addr4;
    ra4[1] <= ra4[0];
    ra4[2] <= ra4[1];
    ra4[3] <= ra4[2];
  end

  assign ram_q1 = rv1    ? ram_val(ra1)    : 8'hEE;
  assign ram_q4 = rv4[3] ? ram_val(ra4[3]) : 8'hEE;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic game_write(input logic [15:0] a);
    @(negedge clk_sys);
    game_we   = 1'b1;
    game_addr = a;
    @(negedge clk_sys);
    game_we   = 1'b0;
  endtask

  task automatic osd_pulse(input string tag, input int exp);
    int c1, c4;
    c1 = 0;
    c4 = 0;
    @(negedge clk_sys);
    osd_status = 1'b1;
    repeat (4) begin
      @(negedge clk_sys);
      if (io1.ioctl_upload_req) c1++;
      if (io4.ioctl_upload_req) c4++;
    end
    osd_status = 1'b0;
    @(negedge clk_sys);
    check_output(tag, c1, exp);
    check_output({tag, "_b"}, c4, exp);
  endtask

  task automatic start_upload();
    @(negedge clk_sys);
    upload_en    = 1'b1;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check_output("pause_req_on", {pause_req4, pause_req1}, 2'b11);
    repeat (18) @(negedge clk_sys);
  endtask

  // Called on the negedge where ram_rd is visible (cycle 1 of the read).
  task automatic finish_read(input logic [7:0] exp);
    int low1, low4, extra;
    low1  = 0;
    low4  = 0;
    extra = 0;
    for (int j = 2; j <= 12; j++) begin
      @(negedge clk_sys);
      if (!io1.ioctl_wait && low1 == 0) low1 = j;
      if (!io4.ioctl_wait && low4 == 0) low4 = j;
      if (ram_rd1 || ram_rd4) extra++;
      if (low1 != 0 && low4 != 0) break;
    end
    check_output("wait_len_lat1", low1, 3);
    check_output("wait_len_lat4", low4, 6);
    check_output("ram_rd_once", extra, 0);
    check_output("din_lat1", io1.ioctl_din, exp);
    check_output("din_lat4", io4.ioctl_din, exp);
  endtask

  task automatic do_read(input int addr);
    logic [15:0] ea;
    ea = 16'hC000 + 16'(addr);
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(addr);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_output("rd_strobe", {ram_rd4, ram_rd1}, 2'b11);
    check_output("rd_addr_lat1", ram_addr1, ea);
    check_output("rd_addr_lat4", ram_addr4, ea);
    check_output("wait_on", {io4.ioctl_wait, io1.ioctl_wait}, 2'b11);
    finish_read(ram_val(ea));
  endtask

  task automatic do_null_read(input int addr);
    int busy;
    busy = 0;
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'(addr);
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_output("null_din_lat1", io1.ioctl_din, 8'h00);
    check_output("null_din_lat4", io4.ioctl_din, 8'h00);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk_sys);
      if (io1.ioctl_wait || io4.ioctl_wait || ram_rd1 || ram_rd4) busy++;
    end
    check_output("null_quiet", busy, 0);
  endtask

  initial begin
    int k;
    int seen;
    int a;

    // Reset values
    repeat (3) @(negedge clk_sys);
    check_output("rst_pause_req", {pause_req4, pause_req1}, 2'b00);
    check_output("rst_ram_rd", {ram_rd4, ram_rd1}, 2'b00);
    check_output("rst_ram_addr", ram_addr1, 16'h0000);
    check_output("rst_din", io1.ioctl_din, 8'h00);
    check_output("rst_wait", {io4.ioctl_wait, io1.ioctl_wait}, 2'b00);
    check_output("rst_upload_req", {io4.ioctl_upload_req, io1.ioctl_upload_req}, 2'b00);
    reset = 1'b0;

    // Dirty tracking and autosave requests
    $display("[TB] dirty tracking");
    autosave = 1'b1;
    osd_pulse("req_clean", 0);
    game_write(16'hC040);
    osd_pulse("req_after_c040", 0);
    game_write(16'hBFFF);
    osd_pulse("req_after_bfff", 0);
    game_write(16'hC03F);
    autosave = 1'b0;
    osd_pulse("req_autosave_off", 0);
    autosave = 1'b1;
    osd_pulse("req_dirty", 1);

    // First upload: request while pausing, pause interrupted at count 10
    $display("[TB] upload with pending request");
    @(negedge clk_sys);
    upload_en    = 1'b1;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check_output("pause_req_next", {pause_req4, pause_req1}, 2'b11);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd5;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_output("wait_pending", {io4.ioctl_wait, io1.ioctl_wait}, 2'b11);
    paused = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (ram_rd1 || ram_rd4) seen++;
    end
    paused = 1'b0;
    @(negedge clk_sys);
    if (ram_rd1 || ram_rd4) seen++;
    paused = 1'b1;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_sys);
      if (ram_rd1) begin
        k = i;
        break;
      end
      if (ram_rd4) seen++;
    end
    check_output("no_early_rd", seen, 0);
    check_output("settle_restart", k, 17);
    check_output("pend_rd_lat4", ram_rd4, 1'b1);
    check_output("pend_addr_lat1", ram_addr1, 16'hC005);
    check_output("pend_addr_lat4", ram_addr4, 16'hC005);
    finish_read(ram_val(16'hC005));

    // Out-of-range reads return zero without touching RAM
    do_null_read(64);
    do_read(6);
    do_null_read(200);
    osd_pulse("req_while_busy", 0);

    // Random stream, never the last byte so the upload stays incomplete
    $display("[TB] random read stream");
    for (int i = 0; i < 10; i++) begin
      a = int'($urandom_range(62, 0));
      do_read(a);
    end
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check_output("drop_pause_req", {pause_req4, pause_req1}, 2'b00);
    osd_pulse("req_incomplete", 1);

    // Upload dropped in the middle of a fetch
    $display("[TB] abort during fetch");
    start_upload();
    do_read(10);
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd20;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_output("abort_in_fetch", ram_rd1, 1'b1);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check_output("abort_wait", {io4.ioctl_wait, io1.ioctl_wait}, 2'b00);
    check_output("abort_pause_req", {pause_req4, pause_req1}, 2'b00);
    check_output("abort_ram_rd", {ram_rd4, ram_rd1}, 2'b00);
    check_output("abort_din_lat1", io1.ioctl_din, ram_val(16'hC00A));
    check_output("abort_din_lat4", io4.ioctl_din, ram_val(16'hC00A));

    // Complete upload clears the dirty flag
    $display("[TB] full upload");
    start_upload();
    for (int i = 0; i < 64; i++) do_read(i);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    osd_pulse("req_after_full", 0);
    game_write(16'hC000);
    osd_pulse("req_redirty", 1);

    // Reset in the middle of a fetch
    $display("[TB] reset during fetch");
    start_upload();
    @(negedge clk_sys);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd7;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    check_output("rst_in_fetch", ram_rd1, 1'b1);
    reset = 1'b1;
    @(negedge clk_sys);
    check_output("mid_rst_pause_req", {pause_req4, pause_req1}, 2'b00);
    check_output("mid_rst_ram_rd", {ram_rd4, ram_rd1}, 2'b00);
    check_output("mid_rst_ram_addr", ram_addr1, 16'h0000);
    check_output("mid_rst_din", io1.ioctl_din, 8'h00);
    check_output("mid_rst_wait", {io4.ioctl_wait, io1.ioctl_wait}, 2'b00);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    osd_pulse("req_after_reset", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
